// File: rtl/bus_mux_driver.sv
// bus_mux_driver: source side of the shared datapath bus.
//
// Resolves the per-source out-enables with a fixed priority (lowest index wins) and
// registers the winning source value onto BusMuxOut. When no source is enabled, the
// bus-keeper holds the last value. Multiple simultaneous enables are flagged as a
// sticky conflict and counted with a saturating counter.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset, clears every output
//   src_out      per-source out-enable, bit i requests source i
//   src_data     flattened source values, source i at [i*WIDTH +: WIDTH]
//   err_clr      synchronous clear of conflict / conflict_cnt
//   BusMuxOut    registered bus value
//   bus_sel      registered index of the source that drove the last transfer
//   bus_valid    high for one cycle after a cycle with any enable set
//   conflict     sticky flag, two or more enables seen in one cycle
//   conflict_cnt saturating count of conflict cycles

module bus_mux_driver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 24,
    parameter int unsigned SELW  = 5,
    parameter int unsigned CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC-1:0]       src_out,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      BusMuxOut,
    output logic [SELW-1:0]       bus_sel,
    output logic                  bus_valid,
    output logic                  conflict,
    output logic [CNTW-1:0]       conflict_cnt
);

    logic [WIDTH-1:0] bus_q, bus_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             conflict_q, conflict_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [SELW-1:0]  win_sel;
    logic [WIDTH-1:0] win_data;
    logic             any_req;
    logic             multi_req;

    // Priority encoder: scan from the top down so the lowest set index is written last.
    always_comb begin
        win_sel  = '0;
        win_data = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_sel  = SELW'(i);
                win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_req   = |src_out;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(src_out & (src_out - 1'b1));

    always_comb begin
        bus_d      = bus_q;
        sel_d      = sel_q;
        valid_d    = any_req;
        conflict_d = conflict_q;
        cnt_d      = cnt_q;

        if (any_req) begin
            bus_d = win_data;
            sel_d = win_sel;
        end

        if (err_clr) begin
            // A conflict coincident with the clear is recorded as the first new event.
            conflict_d = multi_req;
            cnt_d      = multi_req ? CNTW'(1) : '0;
        end else if (multi_req) begin
            conflict_d = 1'b1;
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_q      <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            bus_q      <= bus_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign BusMuxOut    = bus_q;
    assign bus_sel      = sel_q;
    assign bus_valid    = valid_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_mux_driver.sv
// Directed testbench for bus_mux_driver with hand-computed expectations.

module tb_bus_mux_driver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 24;
    localparam int unsigned SELW  = 5;
    localparam int unsigned CNTW  = 8;

    logic                  clk;
    logic                  clr;
    logic [NSRC-1:0]       src_out;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  err_clr;
    logic [WIDTH-1:0]      BusMuxOut;
    logic [SELW-1:0]       bus_sel;
    logic                  bus_valid;
    logic                  conflict;
    logic [CNTW-1:0]       conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bus_mux_driver #(
        .WIDTH(WIDTH),
        .NSRC (NSRC),
        .SELW (SELW),
        .CNTW (CNTW)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .src_out     (src_out),
        .src_data    (src_data),
        .err_clr     (err_clr),
        .BusMuxOut   (BusMuxOut),
        .bus_sel     (bus_sel),
        .bus_valid   (bus_valid),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_bus, input logic [31:0] e_sel,
                             input logic [31:0] e_valid, input logic [31:0] e_conf,
                             input logic [31:0] e_cnt);
        check_eq({tag, ".bus"},      32'(BusMuxOut),    e_bus);
        check_eq({tag, ".sel"},      32'(bus_sel),      e_sel);
        check_eq({tag, ".valid"},    32'(bus_valid),    e_valid);
        check_eq({tag, ".conflict"}, 32'(conflict),     e_conf);
        check_eq({tag, ".cnt"},      32'(conflict_cnt), e_cnt);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [31:0] val);
        src_data[idx*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        clr      = 1'b1;
        src_out  = '0;
        src_data = '0;
        err_clr  = 1'b0;

        // Reset / idle
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("idle", 0, 0, 0, 0, 0);
        end

        // Single transfer, then bus-keeper
        set_src(5, 32'h0000_00A5);
        src_out = 24'h000020;
        tick();
        check_all("single", 32'h0000_00A5, 5, 1, 0, 0);
        src_out = '0;
        tick();
        check_all("keeper", 32'h0000_00A5, 5, 0, 0, 0);

        // Back-to-back sources
        set_src(20, 32'h0000_0100);
        set_src(21, 32'hDEAD_BEEF);
        set_src(19, 32'h1234_5678);
        src_out = 24'h1 << 20;
        tick();
        check_all("b2b_pc", 32'h0000_0100, 20, 1, 0, 0);
        src_out = 24'h1 << 21;
        tick();
        check_all("b2b_mdr", 32'hDEAD_BEEF, 21, 1, 0, 0);
        src_out = 24'h1 << 19;
        tick();
        check_all("b2b_zlow", 32'h1234_5678, 19, 1, 0, 0);
        src_out = '0;
        tick();
        check_all("b2b_idle", 32'h1234_5678, 19, 0, 0, 0);

        // Highest index source
        set_src(23, 32'h0000_0ABC);
        src_out = 24'h800000;
        tick();
        check_all("top_src", 32'h0000_0ABC, 23, 1, 0, 0);

        // Data change while enable held is picked up each edge
        set_src(23, 32'h0000_0DEF);
        tick();
        check_all("resample", 32'h0000_0DEF, 23, 1, 0, 0);
        src_out = '0;
        tick();

        // Conflict resolution
        set_src(3, 32'h1111_1111);
        set_src(16, 32'h2222_2222);
        src_out = 24'h010008;
        tick();
        check_all("conflict", 32'h1111_1111, 3, 1, 1, 1);
        src_out = '0;
        tick();
        check_all("sticky", 32'h1111_1111, 3, 0, 1, 1);

        // Saturation: count starts at 1, 254 more conflicts reach 255
        src_out = 24'h010008;
        for (int i = 0; i < 253; i++) tick();
        check_eq("cnt_254", 32'(conflict_cnt), 254);
        for (int i = 0; i < 47; i++) tick();
        check_all("saturate", 32'h1111_1111, 3, 1, 1, 255);

        // err_clr alone clears status, leaves the bus alone
        src_out = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_all("err_clr", 32'h1111_1111, 3, 0, 0, 0);

        // err_clr together with a new conflict records it
        set_src(9, 32'h0000_0999);
        src_out = 24'h000600;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        src_out = '0;
        check_all("err_clr_conf", 32'h0000_0999, 9, 1, 1, 1);
        tick();

        // Asynchronous reset mid-stream
        set_src(0, 32'hCAFE_F00D);
        src_out = 24'h000001;
        tick();
        check_all("stream", 32'hCAFE_F00D, 0, 1, 1, 1);
        tick();
        check_all("stream2", 32'hCAFE_F00D, 0, 1, 1, 1);
        #3;
        clr = 1'b1;
        #1;
        check_all("async_clr", 0, 0, 0, 0, 0);
        tick();
        check_all("clr_edge", 0, 0, 0, 0, 0);
        #2;
        clr = 1'b0;
        set_src(7, 32'h0000_0077);
        src_out = 24'h000080;
        #1;
        check_all("post_clr", 0, 0, 0, 0, 0);
        tick();
        check_all("first_xfer", 32'h0000_0077, 7, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mux_driver.md
Name: bus_mux_driver

Overview:
- Source side of the shared 32-bit datapath bus: takes the per-source out-enables and source values, and drives BusMuxOut.
- All register-file registers, and every other unit that listens for its own Rn_in-style enable, load from BusMuxOut.
- Registered output stage with a bus-keeper, a fixed-priority resolver, conflict detection and transfer status.
- Sits between the register file, special registers, the control unit and every bus listener.

Parameters:
- WIDTH, 32, data width of every source and of BusMuxOut.
- NSRC, 24, number of bus sources.
  - Index map: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = InPort, 23 = C_sign_extended.
- SELW, 5, width of the encoded select; must satisfy 2^SELW >= NSRC.
- CNTW, 8, width of the conflict counter.

Ports:
- clk, input, 1, rising-edge clock.
- clr, input, 1, asynchronous active-high reset.
- src_out, input, NSRC, per-source out-enable; bit i requests source i onto the bus.
- src_data, input, NSRC*WIDTH, flattened source values; source i occupies bits [i*WIDTH +: WIDTH].
- err_clr, input, 1, synchronous clear of the conflict status.
- BusMuxOut, output, WIDTH, registered bus value.
- bus_sel, output, SELW, registered index of the source that drove the last transfer.
- bus_valid, output, 1, high for one cycle after a cycle in which any src_out bit was set.
- conflict, output, 1, sticky flag: two or more src_out bits were set in the same cycle.
- conflict_cnt, output, CNTW, saturating count of conflict cycles.

Behaviour:
- Reset (clr=1, asynchronous, any time): all outputs go to 0. This covers BusMuxOut, bus_sel, bus_valid, conflict and conflict_cnt. Reset takes priority over every other input.
- Latency: exactly one clock.
  - src_out and src_data sampled at edge N appear on BusMuxOut, bus_sel and bus_valid after edge N.
- Selection: a combinational priority encoder on src_out; the lowest set index wins.
  - On each rising edge with any src_out bit set: BusMuxOut <= src_data[sel]; bus_sel <= sel; bus_valid <= 1.
- Idle (src_out == 0): bus-keeper.
  - BusMuxOut and bus_sel hold their previous values; bus_valid <= 0.
  - Consequence: after reset with no source enabled, BusMuxOut stays 0.
- Conflict (popcount(src_out) >= 2 at an edge):
  - The transfer still completes using the lowest index.
  - conflict <= 1.
  - conflict_cnt increments by 1 and saturates at 2^CNTW-1; it does not wrap.
- Sticky status: conflict stays 1 until err_clr or reset.
- err_clr without a conflict in the same cycle: conflict <= 0, conflict_cnt <= 0.
- err_clr together with a conflict in the same cycle: conflict <= 1, conflict_cnt <= 1. The new event is recorded, not lost.
- err_clr never affects BusMuxOut, bus_sel or bus_valid.
- Back-to-back transfers: a different source may be selected every cycle. bus_valid stays high continuously and BusMuxOut updates every cycle.
- Source changes after sampling: if src_data changes while src_out is held, the new value is taken at each edge; there is no capture-once behaviour.
- Out-of-range: bits of src_out at index >= NSRC do not exist. bus_sel never exceeds NSRC-1.
- Reset mid-transfer: an edge coincident with clr=1 performs no transfer; outputs read 0 while clr=1.

Test Plan:
- Reset / idle: assert clr with src_out=0x000000, release clr, run 5 clocks.
  - Required: BusMuxOut=0, bus_sel=0, bus_valid=0, conflict=0 and conflict_cnt=0 throughout.
- Single transfer with keeper:
  - Set R5 data to 0x0000_00A5 and src_out=0x000020 for one cycle. Required next cycle: BusMuxOut=0x0000_00A5, bus_sel=5, bus_valid=1.
  - Then set src_out=0. Required: BusMuxOut stays 0x0000_00A5 and bus_valid=0.
- Back-to-back sources: drive PC=0x0000_0100 (src_out bit 20), then MDR=0xDEAD_BEEF (bit 21), then Zlow=0x1234_5678 (bit 19) on consecutive cycles.
  - Required: the outputs follow one cycle later in the same order, bus_sel=20, 21, 19, and bus_valid stays high for 3 cycles.
- Conflict resolution: set src_out=0x010008 (R3 and HI) with R3=0x1111_1111 and HI=0x2222_2222.
  - Required next cycle: BusMuxOut=0x1111_1111, bus_sel=3, conflict=1, conflict_cnt=1.
  - Required: conflict stays 1 after src_out returns to 0.
- Saturation and clear:
  - Hold a conflicting src_out for 300 cycles. Required: conflict_cnt=255.
  - Pulse err_clr alone. Required: conflict=0, conflict_cnt=0.
  - Pulse err_clr together with a conflict. Required: conflict=1, conflict_cnt=1.
- Asynchronous reset mid-stream: during continuous transfers of 0xCAFE_F00D, assert clr between clock edges.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: after release, the first enabled transfer appears one cycle after its edge.
